p2s_serializer: RTL and testbench
=================================

Name: p2s_serializer

Overview:
Parametrised parallel-to-serial converter that succeeds the fixed 4-bit free-running serializer. Accepts DATA_W-bit words over a valid/ready handshake and shifts them out one bit per transfer, MSB- or LSB-first. Honours downstream backpressure and flags the first and last bit of each word. Sits between a word-wide producer (register file or FIFO) and a serial link or bit-stream consumer.

Parameters:
DATA_W, 8, word width in bits; legal range 2..64.
LSB_FIRST, 0, shift order: 0 = bit DATA_W-1 first, 1 = bit 0 first.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block accepts a word this cycle
in_data  input  DATA_W  parallel word
ser_ready  input  1  consumer accepts ser_bit this cycle
ser_valid  output  1  ser_bit is valid
ser_bit  output  1  current serial bit
ser_first  output  1  ser_bit is the first bit of a word
ser_last  output  1  ser_bit is the final bit of a word (data bit, or parity bit with PARITY_EN)
busy  output  1  a word is held (equal to ser_valid)

Behaviour:
- Reset (async assert, sync release): state IDLE; shift register and bit counter 0. in_ready=1; ser_valid, ser_bit, ser_first, ser_last, busy all 0.
- States: IDLE, SHIFT (PARITY added with PARITY_EN).
- Accept: in_valid && in_ready. Word loads into the shift register; count = 0; state SHIFT. ser_valid rises the cycle after accept: 1-cycle latency.
- Bit transfer: ser_valid && ser_ready. The next cycle shifts the register one position toward the output end; count increments.
- Output bit: MSB of register when LSB_FIRST=0, otherwise LSB. Outputs are registered or derived combinationally from registers only; no in_* to ser_* combinational path.
- ser_first = SHIFT && count==0. ser_last = SHIFT && count==DATA_W-1 (without PARITY_EN).
- Counter width: $clog2(DATA_W+1). Counter never exceeds DATA_W.
- in_ready = IDLE || (ser_valid && ser_ready && ser_last). This allows back-to-back words with no idle bubble: the last bit of word N is followed by the first bit of word N+1 on the next cycle.
- Simultaneous last-bit transfer and accept: load the new word, count = 0, stay in SHIFT.
- Last-bit transfer without accept: go to IDLE; ser_valid drops next cycle.
- Backpressure: while ser_ready=0, ser_bit, ser_first, ser_last and ser_valid hold stable. The producer's in_data may change freely; it is not sampled outside accept.
- Reset mid-word: the word is discarded and outputs return to reset values immediately. No partial-word resumption.
- Idle output: ser_bit=0 whenever ser_valid=0.

Optional Feature:
Macro: P2S_PARITY_EN.
- Defined: after data bit DATA_W-1 is transferred, the FSM enters PARITY and emits one even-parity bit (XOR of the accepted word, captured at accept). ser_last is asserted on the parity bit only, not on the last data bit. in_ready follows the same rule against this ser_last. A word occupies DATA_W+1 transfers.
- Undefined: no PARITY state and no parity register; DATA_W transfers per word.

Decomposition:
- Package p2s_pkg: state enum (P2S_IDLE, P2S_SHIFT, P2S_PARITY); localparam function for counter width; constant P2S_MAX_W=64 for parameter checking.
- The top asserts the DATA_W range at elaboration.
- One natural sub-module, p2s_bit_counter: counter with load-clear, enable, and terminal-count output at a parameter value. It is reused by the planned s2p_deserializer.

Test Plan:
1. Reset, then DATA_W=8, LSB_FIRST=0, in_data=8'hA5, ser_ready=1 -> ser_bit sequence 1,0,1,0,0,1,0,1 on consecutive cycles; ser_first on bit 0; ser_last on bit 7; accept-to-first-bit latency 1 cycle.
2. LSB_FIRST=1, in_data=8'hA5 -> sequence 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 read from bit 0 upward (bits 0..7 = 1,0,1,0,0,1,0,1). Also check in_data=8'h01 -> 1 then seven 0s.
3. Back-to-back: in_valid held high with 8'hFF then 8'h00 -> 16 contiguous ser_valid cycles (eight 1s then eight 0s); in_ready=1 exactly on the last-bit cycles.
4. Backpressure: ser_ready=0 for 3 cycles at bit 3 of 8'h3C -> ser_bit, ser_first and ser_last hold; sequence completes intact after release.
5. Reset asserted at bit 4 of 8'hF0 -> ser_valid=0 and in_ready=1 immediately; the next word 8'h81 serialises from its first bit.
6. P2S_PARITY_EN, in_data=8'h07 -> 8 data bits then parity bit 1; ser_last only on the 9th bit. For 8'h03 the parity bit is 0.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial converter and its bit counter.
package p2s_pkg;

  localparam int unsigned P2S_MAX_W = 64;

  localparam logic [1:0] P2S_IDLE   = 2'd0;
  localparam logic [1:0] P2S_SHIFT  = 2'd1;
  localparam logic [1:0] P2S_PARITY = 2'd2;

  // Width able to hold 0..w inclusive.
  function automatic int unsigned p2s_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// Bit counter with synchronous clear, enable and a combinational terminal-count flag.
module p2s_bit_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned TERM  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign term_c = (count == CNT_W'(TERM));

endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides.
// Define P2S_PARITY_EN to append an even-parity bit after every word.
module p2s_serializer
  import p2s_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ser_ready,
  output logic              ser_valid,
  output logic              ser_bit,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  localparam int unsigned CNT_W = p2s_cnt_w(DATA_W);

  if (DATA_W < 2 || DATA_W > P2S_MAX_W) begin : g_bad_width
    $error("p2s_serializer: DATA_W must be in 2..64");
  end

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  count;
  logic              cnt_term_c;
  logic              cnt_clr;
  logic              cnt_en;
  logic              accept;
  logic              xfer;
  logic              data_bit;

  assign ser_valid = (state != P2S_IDLE);
  assign busy      = ser_valid;
  assign xfer      = ser_valid && ser_ready;
  assign in_ready  = (state == P2S_IDLE) || (xfer && ser_last);
  assign accept    = in_valid && in_ready;
  assign data_bit  = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_W-1];
  assign ser_first = (state == P2S_SHIFT) && (count == '0);

`ifdef P2S_PARITY_EN
  logic parity;

  assign ser_bit  = (state == P2S_SHIFT)  ? data_bit :
                    (state == P2S_PARITY) ? parity   : 1'b0;
  assign ser_last = (state == P2S_PARITY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^in_data;
    end
  end
`else
  assign ser_bit  = (state == P2S_SHIFT) && data_bit;
  assign ser_last = (state == P2S_SHIFT) && cnt_term_c;
`endif

  // A word boundary (accept or final transfer) restarts the count.
  assign cnt_clr = accept || (xfer && ser_last);
  assign cnt_en  = xfer && !ser_last;

  p2s_bit_counter #(
    .CNT_W (CNT_W),
    .TERM  (DATA_W - 1)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (count),
    .term_c (cnt_term_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= P2S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      P2S_IDLE: begin
        if (accept) state_nxt = P2S_SHIFT;
      end
      P2S_SHIFT: begin
        if (xfer && cnt_term_c) begin
`ifdef P2S_PARITY_EN
          state_nxt = P2S_PARITY;
`else
          state_nxt = accept ? P2S_SHIFT : P2S_IDLE;
`endif
        end
      end
`ifdef P2S_PARITY_EN
      P2S_PARITY: begin
        if (xfer) state_nxt = accept ? P2S_SHIFT : P2S_IDLE;
      end
`endif
      default: state_nxt = P2S_IDLE;
    endcase
  end

  // Shift toward the output end after each data-bit transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= in_data;
    end else if (xfer && (state == P2S_SHIFT)) begin
      if (LSB_FIRST != 0) begin
        shreg <= {1'b0, shreg[DATA_W-1:1]};
      end else begin
        shreg <= {shreg[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: MSB-first and LSB-first instances driven in parallel.
module tb_p2s_serializer;

`ifdef P2S_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct {
    logic [7:0] data;
    logic [0:7] exp_m;
    logic [0:7] exp_l;
    logic       exp_par;
    int         stall_at;
    int         stall_len;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ser_ready;
  logic m_in_ready, m_ser_valid, m_ser_bit, m_ser_first, m_ser_last, m_busy;
  logic l_in_ready, l_ser_valid, l_ser_bit, l_ser_first, l_ser_last, l_busy;

  int passed = 0;
  int total  = 0;
  vec_t vecs[6];

  p2s_serializer #(.DATA_W(8), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .ser_ready(ser_ready), .ser_valid(m_ser_valid),
    .ser_bit(m_ser_bit), .ser_first(m_ser_first), .ser_last(m_ser_last), .busy(m_busy)
  );

  p2s_serializer #(.DATA_W(8), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .ser_ready(ser_ready), .ser_valid(l_ser_valid),
    .ser_bit(l_ser_bit), .ser_first(l_ser_first), .ser_last(l_ser_last), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] act();
    return {m_ser_valid, m_ser_bit, m_ser_first, m_ser_last, m_in_ready, m_busy,
            l_ser_valid, l_ser_bit, l_ser_first, l_ser_last, l_in_ready, l_busy};
  endfunction

  function automatic logic [11:0] exp_of(logic v, logic bm, logic bl, logic f, logic la,
                                         logic ir);
    return {v, bm, f, la, ir, v, v, bl, f, la, ir, v};
  endfunction

  task automatic check(input string name, input logic [11:0] a, input logic [11:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %b expected %b (valid,bit,first,last,in_ready,busy x msb/lsb)",
                  name, a, e);
  endtask

  task automatic send_word(input vec_t v);
    logic bm, bl;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = v.data;
    ser_ready = 1'b1;
    #1 check($sformatf("idle_%h", v.data), act(), exp_of(0, 0, 0, 0, 0, 1));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    for (int k = 0; k < NB; k++) begin
      bm = (k < 8) ? v.exp_m[k] : v.exp_par;
      bl = (k < 8) ? v.exp_l[k] : v.exp_par;
      check($sformatf("w%h_bit%0d", v.data, k), act(),
            exp_of(1, bm, bl, k == 0, k == NB - 1, k == NB - 1));
      if (k == v.stall_at && v.stall_len > 0) begin
        ser_ready = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          @(negedge clk);
          in_data = 8'($urandom);
          check($sformatf("w%h_stall%0d", v.data, s), act(),
                exp_of(1, bm, bl, k == 0, k == NB - 1, 0));
        end
        ser_ready = 1'b1;
      end
      @(negedge clk);
    end
    check($sformatf("done_%h", v.data), act(), exp_of(0, 0, 0, 0, 0, 1));
  endtask

  initial begin
    //            data    msb-first seq  lsb-first seq  par stall
    vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0, -1, 0};
    vecs[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1, -1, 0};
    vecs[2] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0,  3, 3};
    vecs[3] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1, -1, 0};
    vecs[4] = '{8'h03, 8'b00000011, 8'b11000000, 1'b0, -1, 0};
    vecs[5] = '{8'h81, 8'b10000001, 8'b10000001, 1'b0, -1, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ser_ready = 1'b0;
    #12 check("reset", act(), exp_of(0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) send_word(vecs[i]);

    // Back-to-back: FF then 00 with in_valid held, no bubble between words.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    ser_ready = 1'b1;
    @(negedge clk);
    in_data = 8'h00;
    for (int k = 0; k < 2 * NB; k++) begin
      logic b;
      b = ((k % NB) < 8) ? (k < NB) : 1'b0;
      check($sformatf("b2b_bit%0d", k), act(),
            exp_of(1, b, b, (k % NB) == 0, (k % NB) == NB - 1, (k % NB) == NB - 1));
      if (k == NB) in_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_done", act(), exp_of(0, 0, 0, 0, 0, 1));

    // Reset in the middle of F0 (after bit 4 is presented).
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst_w_bit%0d", k), act(),
            exp_of(1, k < 4, k >= 4, k == 0, 0, 0));
      if (k < 4) @(negedge clk);
    end
    rst_n = 1'b0;
    #1 check("mid_reset", act(), exp_of(0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst_n = 1'b1;
    send_word(vecs[5]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
